// File: rtl/video_if.sv
// video_if: pixel stream as driven by the VGA timing generator.
interface video_if;
  logic        CLK;
  logic        HS;
  logic        VS;
  logic        BLANK;
  logic [23:0] RGB;
  modport master (output CLK, HS, VS, BLANK, RGB);
  modport slave  (input HS, VS, BLANK, RGB);
endinterface

// File: rtl/video_timing_monitor.sv
// video_timing_monitor: locks onto incoming sync timing, measures frame geometry and tags pixels with (x, y).
module video_timing_monitor #(
  parameter int CNT_W = 12
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst_n,
  video_if.slave           video_ifs,
  output logic             locked,
  output logic             frame_err,
  output logic [CNT_W-1:0] h_active,
  output logic [CNT_W-1:0] v_active,
  output logic [CNT_W-1:0] h_total,
  output logic [CNT_W-1:0] v_total,
  output logic             pix_valid,
  output logic [23:0]      pix_rgb,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             sof,
  output logic             eol
);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  typedef enum logic [1:0] {WAIT_VS, MEASURE, CHECK, LOCKED} state_t;
  state_t state, nstate;
  logic hs_r, vs_r, blank_r, hs_q, vs_q, blank_q, line_vis, frame_bad;
  logic [23:0] rgb_r;
  logic [CNT_W-1:0] h_cnt, vis_cnt, v_cnt, vl_cnt, h_ref, a_ref, row_cnt;
  logic hs_rise, vs_rise, blank_rise, blank_fall, first_vis, line_bad, sat, bad, same, store, fsm_err;
  logic [CNT_W-1:0] m_ha, m_va, m_ht, m_vt, nx, ny;
  // A line closing on the same edge as VS still belongs to the frame being closed.
  always_comb begin
    hs_rise = hs_r & ~hs_q;
    vs_rise = vs_r & ~vs_q;
    blank_rise = blank_r & ~blank_q;
    blank_fall = ~blank_r & blank_q;
    first_vis = blank_r & (hs_rise | ~line_vis);
    line_bad = hs_rise & ((h_ref != '0 && h_cnt != h_ref) || (vis_cnt != '0 && a_ref != '0 && vis_cnt != a_ref));
    sat = (h_cnt == MAX && !hs_rise) || (vis_cnt == MAX && blank_r && !hs_rise) ||
          (v_cnt == MAX && hs_rise && !vs_rise) || (vl_cnt == MAX && first_vis && !vs_rise);
    bad = frame_bad | line_bad | sat;
    m_ht = hs_rise ? h_cnt : h_ref;
    m_ha = (hs_rise && vis_cnt != '0) ? vis_cnt : a_ref;
    m_vt = v_cnt;
    m_va = vl_cnt;
    same = m_ha == h_active && m_va == v_active && m_ht == h_total && m_vt == v_total;
    store = vs_rise && !bad && state != WAIT_VS && (state == MEASURE || !same);
    fsm_err = vs_rise && state != WAIT_VS && (bad || (state == LOCKED && !same));
    nstate = !vs_rise ? state : (state == WAIT_VS || bad) ? MEASURE : state == MEASURE ? CHECK : same ? LOCKED : CHECK;
    nx = blank_rise ? '0 : (pix_x == MAX ? MAX : pix_x + ONE);
    ny = vs_rise ? '0 : row_cnt;
  end
  always_ff @(posedge pixel_clk) begin
    if (!pixel_rst_n) begin
      {hs_r, vs_r, blank_r, hs_q, vs_q, blank_q, line_vis, frame_bad, rgb_r} <= '0;
      {h_cnt, vis_cnt, v_cnt, vl_cnt, h_ref, a_ref, row_cnt} <= '0;
      {h_active, v_active, h_total, v_total, pix_x, pix_y} <= '0;
      {locked, frame_err, pix_valid, pix_rgb, sof, eol} <= '0;
      state <= WAIT_VS;
    end else begin
      hs_r <= video_ifs.HS;
      vs_r <= video_ifs.VS;
      blank_r <= video_ifs.BLANK;
      rgb_r <= video_ifs.RGB;
      hs_q <= hs_r;
      vs_q <= vs_r;
      blank_q <= blank_r;
      pix_valid <= blank_r;
      pix_rgb <= rgb_r;
      sof <= blank_r && nx == '0 && ny == '0;
      eol <= blank_r & ~video_ifs.BLANK;
      pix_x <= blank_r ? nx : pix_x;
      pix_y <= blank_r ? ny : pix_y;
      row_cnt <= vs_rise ? '0 : row_cnt + CNT_W'(blank_fall && row_cnt != MAX);
      h_cnt <= hs_rise ? ONE : (h_cnt == MAX ? MAX : h_cnt + ONE);
      vis_cnt <= hs_rise ? CNT_W'(blank_r) : vis_cnt + CNT_W'(blank_r && vis_cnt != MAX);
      line_vis <= hs_rise ? blank_r : line_vis | blank_r;
      v_cnt <= vs_rise ? CNT_W'(hs_rise) : v_cnt + CNT_W'(hs_rise && v_cnt != MAX);
      vl_cnt <= vs_rise ? CNT_W'(first_vis) : vl_cnt + CNT_W'(first_vis && vl_cnt != MAX);
      h_ref <= vs_rise ? '0 : hs_rise ? h_cnt : h_ref;
      a_ref <= vs_rise ? '0 : (hs_rise && vis_cnt != '0) ? vis_cnt : a_ref;
      frame_bad <= vs_rise ? 1'b0 : bad;
      state <= nstate;
      locked <= nstate == LOCKED;
      frame_err <= fsm_err;
      if (store) {h_active, v_active, h_total, v_total} <= {m_ha, m_va, m_ht, m_vt};
    end
  end
endmodule

// File: tb/tb_video_timing_monitor.sv
// tb_video_timing_monitor: directed checks of lock, geometry, pixel tagging, error and reset behaviour
// on a scaled-down generator timing (8x6 active, 14x11 total; sync first so HS and VS rise together).
module tb_video_timing_monitor;
  localparam int W = 12;
  logic pixel_clk = 1'b0;
  logic pixel_rst_n = 1'b0;
  logic locked, frame_err, pix_valid, sof, eol;
  logic [W-1:0] h_active, v_active, h_total, v_total, pix_x, pix_y;
  logic [23:0] pix_rgb;
  int errors = 0, checks = 0;
  int hpw = 2, hbp = 2, hdisp = 8, hfp = 2, vpw = 2, vbp = 2, vdisp = 6, vfp = 1;
  int next_hdisp = 8, short_v = -1, gh = 5, gv = 6, d_x = 0, d_y = 0, err_cnt = 0;
  bit hold = 0, vs_edge = 0, prev_vs = 0, lk_before = 0;
  logic d_blank = 1'b0;
  logic [23:0] d_rgb = '0, rgb_seq = 24'h123456;
  video_if vif();
  assign vif.CLK = pixel_clk;
  always #5 pixel_clk = ~pixel_clk;

  video_timing_monitor #(.CNT_W(W)) dut (
    .pixel_clk(pixel_clk), .pixel_rst_n(pixel_rst_n), .video_ifs(vif),
    .locked(locked), .frame_err(frame_err),
    .h_active(h_active), .v_active(v_active), .h_total(h_total), .v_total(v_total),
    .pix_valid(pix_valid), .pix_rgb(pix_rgb), .pix_x(pix_x), .pix_y(pix_y),
    .sof(sof), .eol(eol)
  );

  task automatic gen_cyc();
    int lend;
    lend = hpw + hbp + hdisp + hfp - ((gv == short_v) ? 1 : 0);
    vif.HS = !hold && gh < hpw;
    vif.VS = !hold && gv < vpw;
    d_blank = hold || (gh >= hpw + hbp && gh < hpw + hbp + hdisp && gv >= vpw + vbp && gv < vpw + vbp + vdisp);
    vif.BLANK = d_blank;
    d_rgb = rgb_seq;
    vif.RGB = d_rgb;
    rgb_seq = rgb_seq + 24'h010203;
    d_x = gh - hpw - hbp;
    d_y = gv - vpw - vbp;
    vs_edge = vif.VS && !prev_vs;
    prev_vs = vif.VS;
    if (!hold) begin
      gh++;
      if (gh == lend) begin gh = 0; gv++; end
      if (gv == vpw + vbp + vdisp + vfp) begin gv = 0; hdisp = next_hdisp; short_v = -1; end
    end
    @(posedge pixel_clk);
    @(negedge pixel_clk);
    if (frame_err === 1'b1) err_cnt++;
  endtask

  task automatic to_vs();
    int n = 0;
    do begin gen_cyc(); n++; end while (!vs_edge && n < 1000);
    lk_before = locked;
    checks++;
    if (!vs_edge) begin errors++; $display("FAIL vs_wait: no VS rise within %0d cycles", n); end
    gen_cyc();
  endtask

  task automatic test_reset();
    pixel_rst_n = 1'b0;
    repeat (3) gen_cyc();
    checks++;
    if ({locked, frame_err, pix_valid, sof, eol} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 00000", {locked, frame_err, pix_valid, sof, eol});
    end
    checks++;
    if ({h_active, v_active, h_total, v_total} !== 48'h0) begin
      errors++; $display("FAIL reset_geom: got %0d %0d %0d %0d expected 0 0 0 0", h_active, v_active, h_total, v_total);
    end
    checks++;
    if ({pix_x, pix_y, pix_rgb} !== 48'h0) begin
      errors++; $display("FAIL reset_pix: got x=%0d y=%0d rgb=%h expected 0", pix_x, pix_y, pix_rgb);
    end
  endtask

  task automatic test_nominal_lock();
    pixel_rst_n = 1'b1;
    err_cnt = 0;
    to_vs();
    to_vs();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: locked=%b after 2nd VS expected 0", locked); end
    to_vs();
    checks++;
    if ({lk_before, locked} !== 2'b01) begin
      errors++; $display("FAIL lock_latency: got before/after=%b%b expected 01", lk_before, locked);
    end
    checks++;
    if ({h_active, v_active, h_total, v_total} !== {12'd8, 12'd6, 12'd14, 12'd11}) begin
      errors++; $display("FAIL lock_geom: got %0d %0d %0d %0d expected 8 6 14 11", h_active, v_active, h_total, v_total);
    end
    repeat (7) to_vs();
    checks++;
    if (err_cnt != 0 || locked !== 1'b1) begin
      errors++; $display("FAIL lock_hold: got err_pulses=%0d locked=%b expected 0 1", err_cnt, locked);
    end
  endtask

  task automatic test_pixel_coords();
    int valid_cnt = 0, sof_cnt = 0, eol_cnt = 0, eol_x_bad = 0, bad = 0, last_x = -1, last_y = -1, e_x, e_y;
    logic e_blank;
    logic [23:0] e_rgb;
    err_cnt = 0;
    for (int i = 0; i < 154; i++) begin
      e_blank = d_blank; e_x = d_x; e_y = d_y; e_rgb = d_rgb;
      gen_cyc();
      if (pix_valid !== e_blank || sof !== (e_blank && e_x == 0 && e_y == 0) || eol !== (e_blank && !d_blank) ||
          (e_blank && (pix_x !== W'(e_x) || pix_y !== W'(e_y) || pix_rgb !== e_rgb))) bad++;
      if (pix_valid === 1'b1) begin valid_cnt++; last_x = int'(pix_x); last_y = int'(pix_y); end
      if (sof === 1'b1) sof_cnt++;
      if (eol === 1'b1) begin eol_cnt++; if (pix_x !== 12'd7) eol_x_bad++; end
    end
    checks++;
    if (valid_cnt != 48) begin errors++; $display("FAIL pix_count: got %0d expected 48", valid_cnt); end
    checks++;
    if (sof_cnt != 1) begin errors++; $display("FAIL sof_count: got %0d expected 1", sof_cnt); end
    checks++;
    if (eol_cnt != 6 || eol_x_bad != 0) begin
      errors++; $display("FAIL eol: got count=%0d off_x=%0d expected 6 0", eol_cnt, eol_x_bad);
    end
    checks++;
    if (last_x != 7 || last_y != 5) begin errors++; $display("FAIL last_pix: got %0d,%0d expected 7,5", last_x, last_y); end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL pix_model: got %0d differing cycles expected 0", bad); end
    checks++;
    if (err_cnt != 0 || locked !== 1'b1) begin
      errors++; $display("FAIL pix_lock: got err_pulses=%0d locked=%b expected 0 1", err_cnt, locked);
    end
  endtask

  task automatic test_short_line();
    short_v = 3;
    err_cnt = 0;
    to_vs();
    checks++;
    if ({frame_err, locked} !== 2'b10) begin
      errors++; $display("FAIL short_err: got err/locked=%b%b expected 10", frame_err, locked);
    end
    to_vs();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL short_relock_early: locked=%b expected 0", locked); end
    to_vs();
    checks++;
    if (locked !== 1'b1 || err_cnt != 1) begin
      errors++; $display("FAIL short_relock: got locked=%b err_pulses=%0d expected 1 1", locked, err_cnt);
    end
  endtask

  task automatic test_saturation();
    int n = 0;
    while (!(gv == 5 && gh == 0) && n < 500) begin gen_cyc(); n++; end
    hold = 1'b1;
    err_cnt = 0;
    repeat (5000) gen_cyc();
    checks++;
    if ({pix_valid, pix_x} !== {1'b1, 12'hfff}) begin
      errors++; $display("FAIL sat_pix_x: got valid=%b x=%0d expected 1 4095", pix_valid, pix_x);
    end
    hold = 1'b0;
    gh = 0;
    gv = 0;
    to_vs();
    checks++;
    if ({frame_err, locked} !== 2'b10 || err_cnt != 1) begin
      errors++; $display("FAIL sat_err: got err/locked=%b%b pulses=%0d expected 10 1", frame_err, locked, err_cnt);
    end
    to_vs();
    to_vs();
    checks++;
    if (locked !== 1'b1 || h_total !== 12'd14) begin
      errors++; $display("FAIL sat_relock: got locked=%b h_total=%0d expected 1 14", locked, h_total);
    end
  endtask

  task automatic test_res_change();
    next_hdisp = 5;
    err_cnt = 0;
    to_vs();
    checks++;
    if (locked !== 1'b1 || err_cnt != 0) begin
      errors++; $display("FAIL res_old: got locked=%b pulses=%0d expected 1 0", locked, err_cnt);
    end
    to_vs();
    checks++;
    if ({frame_err, locked} !== 2'b10) begin
      errors++; $display("FAIL res_err: got err/locked=%b%b expected 10", frame_err, locked);
    end
    to_vs();
    checks++;
    if (locked !== 1'b1 || {h_active, v_active, h_total, v_total} !== {12'd5, 12'd6, 12'd11, 12'd11} || err_cnt != 1) begin
      errors++; $display("FAIL res_relock: got locked=%b geom %0d %0d %0d %0d pulses=%0d expected 1 5 6 11 11 1",
                         locked, h_active, v_active, h_total, v_total, err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(gv == 5 && gh == 6) && n < 500) begin gen_cyc(); n++; end
    checks++;
    if ({locked, pix_valid} !== 2'b11) begin
      errors++; $display("FAIL rst_pre: got locked/valid=%b%b expected 11", locked, pix_valid);
    end
    pixel_rst_n = 1'b0;
    gen_cyc();
    pixel_rst_n = 1'b1;
    checks++;
    if ({locked, frame_err, pix_valid, sof, eol, h_active, v_active, h_total, v_total, pix_x, pix_y, pix_rgb} !== '0) begin
      errors++; $display("FAIL rst_mid_zero: got locked=%b valid=%b h_act=%0d h_tot=%0d x=%0d y=%0d rgb=%h expected all 0",
                         locked, pix_valid, h_active, h_total, pix_x, pix_y, pix_rgb);
    end
    to_vs();
    to_vs();
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL rst_relock_early: locked=%b expected 0", locked); end
    to_vs();
    checks++;
    if ({lk_before, locked} !== 2'b01 || h_active !== 12'd5) begin
      errors++; $display("FAIL rst_relock: got before/after=%b%b h_active=%0d expected 01 5", lk_before, locked, h_active);
    end
  endtask

  initial begin
    vif.HS = 1'b0;
    vif.VS = 1'b0;
    vif.BLANK = 1'b0;
    vif.RGB = '0;
    test_reset();
    test_nominal_lock();
    test_pixel_coords();
    test_short_line();
    test_saturation();
    test_res_change();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/video_timing_monitor.md
Name: video_timing_monitor

Overview:
- Receiving end of the `video_if` pixel stream: a slave that consumes `HS`/`VS`/`BLANK`/`RGB` as driven by the team's VGA timing generator.
- Measures the frame geometry and locks onto a stable timing.
- Emits per-pixel (x, y) coordinates alongside the RGB data, and flags timing instability.
- Sits in front of any capture/processing logic that needs pixel positions rather than raw sync.

Parameters:
- `CNT_W`, 12, width of all horizontal/vertical counters and measurement outputs; counters saturate at 2^CNT_W-1.

Ports:
- `pixel_clk`, input, 1, pixel clock; all logic on its rising edge.
- `pixel_rst_n`, input, 1, synchronous active-low reset.
- `video_ifs`, `video_if.slave`, -, incoming stream. Uses `HS` (active-high pulse), `VS` (active-high pulse), `BLANK` (1 = visible pixel), `RGB[23:0]`. `CLK` unused.
- `locked`, output, 1, timing stable for two consecutive identical frames.
- `frame_err`, output, 1, one-cycle pulse on a frame mismatch or saturation.
- `h_active`, output, `CNT_W`, visible pixels per line.
- `v_active`, output, `CNT_W`, visible lines per frame.
- `h_total`, output, `CNT_W`, clocks per line (`HS` rise to `HS` rise).
- `v_total`, output, `CNT_W`, lines per frame (`HS` rises between `VS` rises).
- `pix_valid`, output, 1, `pix_rgb`/`pix_x`/`pix_y` hold a visible pixel.
- `pix_rgb`, output, 24, pixel data.
- `pix_x`, output, `CNT_W`, column within the active area.
- `pix_y`, output, `CNT_W`, row within the active area.
- `sof`, output, 1, with `pix_valid`: first visible pixel of a frame (x=0, y=0).
- `eol`, output, 1, with `pix_valid`: last visible pixel of a line.

Behaviour:
- **Reset:** while `pixel_rst_n`=0 at a clock edge, every output and all internal state go to 0 and the FSM goes to `WAIT_VS`.
  - Reset is legal at any point mid-frame.
  - Measurement restarts from scratch; no stored geometry survives reset.
- **Input stage:**
  - All `video_ifs` inputs are registered once; edge detection compares the registered value with its previous value.
  - Frame boundary = `VS` rising edge. Line boundary = `HS` rising edge.
- **Pixel path (independent of lock):**
  - Latency is 2 `pixel_clk` cycles from an input sample to `pix_*`.
  - `pix_valid` = delayed `BLANK`; `pix_rgb` = delayed `RGB`.
  - `pix_x` clears to 0 on the first visible pixel of each run (`BLANK` rise) and increments per visible pixel.
  - `pix_y` clears on each `VS` rise and increments once per `BLANK` fall, so the first visible line is row 0.
  - `sof` = `pix_valid` & x=0 & y=0.
  - `eol` = `pix_valid` & (next registered `BLANK`=0).
  - With `pix_valid`=0, `pix_x`/`pix_y` hold their values and `sof`/`eol` are 0.
- **Measurement counters** (all saturate at all-ones and never wrap):
  - Cycles since last `HS` rise.
  - Visible pixels in the current line.
  - Lines since `VS` rise.
  - Lines containing at least one visible pixel.
- **Per-frame consistency:**
  - Within a frame, every line must have the same cycle count and the same visible count (lines with zero visible pixels are exempt from the visible check).
  - Any difference or any saturation sets an internal `frame_bad` flag, which is cleared at each `VS` rise.
- **FSM** (evaluated at each `VS` rise; nothing changes between `VS` rises except counters and the flag):
  - `WAIT_VS`: discard the partial frame; go to `MEASURE`.
  - `MEASURE`: if `frame_bad`, stay. Else store the four measurements into `h_active`/`v_active`/`h_total`/`v_total` and go to `CHECK`.
  - `CHECK`: if the new measurements equal the stored ones and not `frame_bad`, set `locked`=1 and go to `LOCKED`. Else overwrite the stored values (or go to `MEASURE` if `frame_bad`) and stay in `CHECK`.
  - `LOCKED`: if equal and not `frame_bad`, stay. Else pulse `frame_err`, clear `locked`, then store the new values and go to `CHECK` (or `MEASURE` if `frame_bad`).
- **Output timing:** `locked`, `frame_err` and the measurement outputs update 1 cycle after the registered `VS` rise is detected.
- **`frame_err` in non-locked states:** also pulses in `CHECK` and `MEASURE` whenever `frame_bad` is set at `VS` rise.
- **Simultaneous `HS` and `VS` rise:** `VS` closes the frame using the line count before the `HS` increment. The new frame's line count starts at 0, and that `HS` is its first line.

Test Plan:
- **Nominal lock:** generator-style timing 800x480, HFP/HPULSE/HBP = 40/48/40, VFP/VPULSE/VBP = 13/3/29, reset released mid-frame.
  - `locked` rises 1 cycle after the 3rd `VS` rise with `h_active`=800, `v_active`=480, `h_total`=928, `v_total`=525.
  - `frame_err` stays 0 for 10 frames.
- **Pixel coordinates:** on the same stream, per frame:
  - exactly 384000 `pix_valid` cycles;
  - one `sof` at x=0, y=0;
  - 480 `eol` pulses, each at x=799;
  - last pixel at x=799, y=479;
  - `pix_rgb` equals the input `RGB` 2 cycles earlier.
- **Resolution change while locked:** switch to `HDISP`=640 (total 768).
  - One `frame_err` pulse at the end of the first 640 frame, and `locked` drops.
  - `locked` rises again at the end of the next frame with `h_active`=640, `h_total`=768.
- **Single short line:** one line of 927 cycles inside a locked frame.
  - `frame_err` pulses at that frame's `VS` rise and `locked` drops.
  - With the stream otherwise unchanged, `locked` rises again 2 `VS` rises later.
- **Saturation:** `BLANK` held high for 5000 cycles with `CNT_W`=12.
  - Internal counts stop at 4095 (no wrap).
  - `frame_err` pulses at the next `VS` rise, and `locked`=0.
- **Reset mid-operation:** assert `pixel_rst_n`=0 for 1 cycle while locked, mid-line.
  - All outputs are 0 on the next cycle.
  - `locked` returns only after the 3rd subsequent `VS` rise.
